// File: rtl/serial_transmit_pkg.sv
// Shared constants, types and slot helpers for the framed serial transmitter.
// A frame is WORD_W data bits MSB-first followed by a single marker bit.
package serial_transmit_pkg;

  localparam int   WORD_W     = 8;
  localparam int   FRAME_BITS = 9;
  localparam logic MARKER_BIT = 1'b0;
  localparam int   SLOT_W     = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LOAD_SLOT   = slot_t'(FRAME_BITS - 1);
  localparam slot_t MARKER_PREV = slot_t'(FRAME_BITS - 2);

  // What the upcoming clock edge does, judged from the slot currently held.
  typedef enum logic [1:0] {
    PH_LOAD,
    PH_DATA,
    PH_MARKER
  } phase_e;

  function automatic phase_e edge_phase(input slot_t slot);
    if (slot == LOAD_SLOT)
      return PH_LOAD;
    else if (slot == MARKER_PREV)
      return PH_MARKER;
    else
      return PH_DATA;
  endfunction

  function automatic slot_t next_slot(input slot_t slot);
    return (slot == LOAD_SLOT) ? '0 : slot + slot_t'(1);
  endfunction

endpackage

// File: rtl/serial_transmit_if.sv
// Word handshake plus serial/status outputs of the transmitter.
// The master side feeds words and watches the line; the slave side is the transmitter.
interface serial_transmit_if #(
  parameter int DEPTH = 4
);
  import serial_transmit_pkg::*;

  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  word_t              data_in;
  logic               data_valid;
  logic               data_ready;
  logic               txd;
  logic               frame_sent;
  logic               frame_is_data;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  txd,
    input  frame_sent,
    input  frame_is_data,
    input  fifo_level
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output txd,
    output frame_sent,
    output frame_is_data,
    output fifo_level
  );

endinterface

// File: rtl/serial_transmit_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head word.
// A push into a full FIFO is dropped even when a pop happens on the same edge.
module tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == LEVEL_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push_ok && !rst)
      mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_transmit.sv
// Framed serial transmitter: queues words and emits back-to-back 9-bit frames,
// sending IDLE_WORD frames whenever nothing is queued at the load edge.
module serial_transmit
  import serial_transmit_pkg::*;
#(
  parameter int    DEPTH     = 4,
  parameter word_t IDLE_WORD = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  serial_transmit_if.slave   bus
);

  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  slot_t              slot;
  logic [WORD_W-2:0]  shreg;
  logic               data_flag;
  logic               txd_q;
  logic               frame_sent_q;
  logic               frame_is_data_q;

  word_t              fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               push;
  logic               pop;
  word_t              load_word;

  assign push      = bus.data_valid && !fifo_full;
  assign pop       = (slot == LOAD_SLOT) && !fifo_empty;
  assign load_word = fifo_empty ? IDLE_WORD : fifo_dout;

  tx_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // The MSB leaves on the load edge, so only the remaining seven bits are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot            <= LOAD_SLOT;
      shreg           <= '0;
      data_flag       <= 1'b0;
      txd_q           <= 1'b1;
      frame_sent_q    <= 1'b0;
      frame_is_data_q <= 1'b0;
    end else begin
      slot            <= next_slot(slot);
      frame_sent_q    <= 1'b0;
      frame_is_data_q <= 1'b0;
      unique case (edge_phase(slot))
        PH_LOAD: begin
          shreg     <= load_word[WORD_W-2:0];
          data_flag <= !fifo_empty;
          txd_q     <= load_word[WORD_W-1];
        end
        PH_DATA: begin
          txd_q <= shreg[WORD_W-2];
          shreg <= {shreg[WORD_W-3:0], 1'b0};
        end
        PH_MARKER: begin
          txd_q           <= MARKER_BIT;
          frame_sent_q    <= 1'b1;
          frame_is_data_q <= data_flag;
        end
        default: begin
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_ready    = !fifo_full;
  assign bus.txd           = txd_q;
  assign bus.frame_sent    = frame_sent_q;
  assign bus.frame_is_data = frame_is_data_q;
  assign bus.fifo_level    = fifo_level;

endmodule

// File: tb/tb_serial_transmit.sv
// Bench for serial_transmit: fixed vectors, directed frame sequences and
// random traffic compared against a queue-based model of the frame stream.
module tb_serial_transmit;
  import serial_transmit_pkg::*;

  localparam int    DEPTH = 4;
  localparam word_t IDLE  = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_transmit_if #(.DEPTH(DEPTH)) bus();

  serial_transmit #(
    .DEPTH     (DEPTH),
    .IDLE_WORD (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: the queue holds accepted words; pos is the bit index within the frame.
  word_t mq[$];
  int    pos = 8;
  word_t cur = IDLE;
  bit    cur_data = 1'b0;
  logic  exp_txd = 1'b1;
  logic  exp_fs = 1'b0;
  logic  exp_fd = 1'b0;
  bit    last_accept = 1'b0;
  logic [7:0] cap = '0;
  word_t rx_q[$];

  typedef struct {
    logic  r;
    logic  v;
    word_t d;
    logic  txd;
    logic  fs;
    logic  fd;
    int    lvl;
  } vec_t;

  vec_t vecs[19];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input word_t d);
    rst = r;
    bus.data_valid = v;
    bus.data_in = d;
    if (r) begin
      mq.delete();
      pos = 8;
      cur = IDLE;
      cur_data = 1'b0;
      last_accept = 1'b0;
      exp_txd = 1'b1;
      exp_fs = 1'b0;
      exp_fd = 1'b0;
    end else begin
      last_accept = v && (mq.size() < DEPTH);
      if (pos == 8) begin
        pos = 0;
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          cur_data = 1'b1;
        end else begin
          cur = IDLE;
          cur_data = 1'b0;
        end
      end else begin
        pos++;
      end
      if (last_accept)
        mq.push_back(d);
      exp_txd = (pos == 8) ? 1'b0 : cur[7-pos];
      exp_fs = (pos == 8);
      exp_fd = (pos == 8) && cur_data;
    end
    @(posedge clk);
    #1;
    if (bus.frame_sent === 1'b1 && bus.frame_is_data === 1'b1)
      rx_q.push_back(cap);
    cap = {cap[6:0], bus.txd};
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".txd"}, bus.txd, exp_txd);
    check1({tag, ".frame_sent"}, bus.frame_sent, exp_fs);
    check1({tag, ".frame_is_data"}, bus.frame_is_data, exp_fd);
    check1({tag, ".fifo_level"}, bus.fifo_level, mq.size());
    check1({tag, ".data_ready"}, bus.data_ready, (mq.size() < DEPTH) ? 1 : 0);
  endtask

  task automatic idleStep(input string tag);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] pat;
    int i;

    bus.data_valid = 1'b0;
    bus.data_in = '0;

    // Reset at edge 0, idle frame on edges 1..9, 8'hA5 pushed at edge 2 and sent 10..18.
    pat = 8'hA5;
    vecs[0] = '{r: 1'b1, v: 1'b0, d: 8'h00, txd: 1'b1, fs: 1'b0, fd: 1'b0, lvl: 0};
    for (int e = 1; e <= 18; e++) begin
      vecs[e].r   = 1'b0;
      vecs[e].v   = (e == 2);
      vecs[e].d   = (e == 2) ? 8'hA5 : 8'h00;
      vecs[e].txd = (e >= 10 && e <= 17) ? pat[17-e] : 1'b0;
      vecs[e].fs  = (e == 9 || e == 18);
      vecs[e].fd  = (e == 18);
      vecs[e].lvl = (e >= 2 && e < 10) ? 1 : 0;
    end
    for (int e = 0; e <= 18; e++) begin
      applyStimulus(vecs[e].r, vecs[e].v, vecs[e].d);
      check1($sformatf("vec%0d.txd", e), bus.txd, vecs[e].txd);
      check1($sformatf("vec%0d.frame_sent", e), bus.frame_sent, vecs[e].fs);
      check1($sformatf("vec%0d.frame_is_data", e), bus.frame_is_data, vecs[e].fd);
      check1($sformatf("vec%0d.fifo_level", e), bus.fifo_level, vecs[e].lvl);
    end

    // Push on the load edge into an empty FIFO: no bypass.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("lp_rst");
    for (int e = 1; e <= 9; e++) idleStep("lp_idle");
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkOutput("lp_push");
    for (int e = 11; e <= 18; e++) idleStep("lp_frame");
    check1("lp.idle_marker_sent", bus.frame_sent, 1);
    check1("lp.idle_marker_kind", bus.frame_is_data, 0);
    for (int e = 19; e <= 26; e++) idleStep("lp_data");
    check1("lp.byte", cap, 8'h3C);
    idleStep("lp_marker");
    check1("lp.data_marker_sent", bus.frame_sent, 1);
    check1("lp.data_marker_kind", bus.frame_is_data, 1);

    // Fill and backpressure with words 01..06 offered continuously.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("fill_rst");
    rx_q.delete();
    i = 0;
    for (int e = 1; e <= 72; e++) begin
      applyStimulus(1'b0, i < 6, (i < 6) ? word_t'(i + 1) : 8'h00);
      checkOutput("fill");
      if (last_accept) i++;
      if (e == 9) begin
        check1("fill.level_full", bus.fifo_level, 4);
        check1("fill.ready_low", bus.data_ready, 0);
        check1("fill.accepted_before_pop", i, 4);
      end
    end
    check1("fill.accepted_total", i, 6);
    check1("fill.frames", rx_q.size(), 6);
    for (int k = 0; k < 6 && k < rx_q.size(); k++)
      check1($sformatf("fill.word%0d", k), rx_q[k], k + 1);

    // Simultaneous push and pop at level 2 on a load edge.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("pp_rst");
    idleStep("pp");
    applyStimulus(1'b0, 1'b1, 8'h11);
    checkOutput("pp_push1");
    applyStimulus(1'b0, 1'b1, 8'h22);
    checkOutput("pp_push2");
    for (int e = 4; e <= 9; e++) idleStep("pp");
    applyStimulus(1'b0, 1'b1, 8'h33);
    checkOutput("pp_load");
    check1("pp.level_kept", bus.fifo_level, 2);
    for (int e = 11; e <= 17; e++) idleStep("pp");
    check1("pp.older_word", cap, 8'h11);

    // Reset in slot 4 of a data frame with three words still queued.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("mr_rst");
    idleStep("mr");
    for (int e = 2; e <= 5; e++) begin
      applyStimulus(1'b0, 1'b1, word_t'(8'h40 + e));
      checkOutput("mr_push");
    end
    for (int e = 6; e <= 13; e++) idleStep("mr");
    check1("mr.level_before", bus.fifo_level, 3);
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("mr_abort");
    check1("mr.txd", bus.txd, 1);
    check1("mr.level", bus.fifo_level, 0);
    check1("mr.ready", bus.data_ready, 1);
    for (int e = 15; e <= 22; e++) idleStep("mr_after");
    check1("mr.idle_bits", cap, 8'h00);
    idleStep("mr_marker");
    check1("mr.marker_sent", bus.frame_sent, 1);
    check1("mr.marker_kind", bus.frame_is_data, 0);

    // Random traffic with occasional resets.
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rnd_rst");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, word_t'($urandom));
      checkOutput("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_transmit.md
Name: serial_transmit

Overview:
- Transmit-side counterpart of the single-wire framed serial link.
- Accepts 8-bit words through a valid/ready handshake and buffers them in a small FIFO.
- Emits a continuous stream of 9-bit frames on txd, one bit per clk.
- Frame format: 8 data bits MSB-first, then one marker bit of 0. When no word is queued, an idle frame carrying IDLE_WORD is sent so frame alignment at the receiver never breaks.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, minimum 2
IDLE_WORD, 8'h00, payload sent when FIFO is empty at frame load

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  8  word to transmit
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  FIFO can accept a word (not full)
txd  output  1  serial line, registered
frame_sent  output  1  one-cycle pulse, high during the marker-bit cycle of every frame
frame_is_data  output  1  valid with frame_sent: 1 = FIFO word, 0 = idle frame
fifo_level  output  clog2(DEPTH)+1  words currently queued

Behaviour:
- Reset values: txd=1, frame_sent=0, frame_is_data=0, fifo_level=0, data_ready=1. The slot counter resets to 8 and the FIFO is flushed.
- Slot counter runs 0..8 and wraps 8->0. Each frame is exactly 9 clk cycles, back-to-back with no gaps.
- Load edge (slot 8 -> 0, including the first edge after rst falls):
  - If FIFO is non-empty, pop the head into the shift register and set the data flag to 1.
  - Otherwise load IDLE_WORD and set the data flag to 0.
  - txd <= loaded word bit 7.
- Slots 1..7: txd <= bits 6..0 in order; the shift register shifts left.
- Entering slot 8: txd <= 0 (marker), frame_sent <= 1, frame_is_data <= data flag. Both frame_sent and frame_is_data are 0 in all other slots.
- Push rule: a push occurs on an edge where data_valid && data_ready. data_ready = !full, combinational from the FIFO count.
- When full, no push occurs even if a pop happens on the same edge.
- Simultaneous push and pop when not full: both happen and fifo_level is unchanged.
- No bypass: a word pushed on the load edge is not sent in that frame. The FIFO sampled before the edge is empty, so an idle frame goes out.
- FIFO pointers wrap modulo DEPTH. fifo_level is updated on the same edge as push/pop.
- data_in is sampled only at push. The shift register holds the popped copy, so upstream may change data_in freely after the handshake.
- Reset mid-frame: the frame is aborted immediately and queued words are discarded. Outputs take reset values on that edge, and the next frame starts with a load on the first non-reset edge.
- data_valid while rst=1 is ignored.

Decomposition:
- Shared package: WORD_W=8, FRAME_BITS=9, MARKER_BIT=1'b0, LOAD_SLOT=8.
- One sub-module: tx_fifo, a synchronous FIFO parameterised on DEPTH and WORD_W.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, level.
- serial_transmit holds the slot counter, shift register and output registers.

Test Plan:
- Idle after reset: release rst at edge 0, no pushes. txd over edges 1..9 = 0,0,0,0,0,0,0,0,0. frame_sent=1 at edge 9 with frame_is_data=0; this repeats every 9 edges.
- Single word: push 8'hA5 at edge 2. Edges 10..17 txd = 1,0,1,0,0,1,0,1. Edge 18 gives txd=0, frame_sent=1, frame_is_data=1. fifo_level goes 1 after edge 2, then 0 after edge 10.
- Fill and backpressure (DEPTH=4): hold data_valid high with 8'h01..8'h06 from edge 2.
  - data_ready drops once fifo_level=4.
  - Exactly 4 words are accepted before the first pop.
  - Frames emit 01,02,03,04 in order, then 05 and 06 as they are accepted, with no loss or duplication.
- Push on load edge into an empty FIFO: push 8'h3C at edge 10. Frame at edges 10..18 is idle (frame_is_data=0); 8'h3C is sent at edges 19..26, with its marker at edge 27.
- Simultaneous push and pop with fifo_level=2 at a load edge: level stays 2 and the popped word is the older one.
- Reset mid-frame: assert rst at slot 4 of a data frame with fifo_level=3.
  - Next edge: txd=1, fifo_level=0, data_ready=1.
  - After release, the first frame is idle.
